// File: rtl/rice_csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rice_csr_arbiter
// Brief    : Round-robin arbiter sharing one non-posted CSR bus between
//            REQUESTERS masters. Optional watchdog: RICE_CSR_ARBITER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rice_csr_arbiter #(
    parameter int REQUESTERS    = 2,
    parameter int XLEN          = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int TIMEOUT       = 255
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [REQUESTERS-1:0]                 i_request,
    input  logic [REQUESTERS-1:0]                 i_write,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]   i_address,
    input  logic [REQUESTERS*XLEN-1:0]            i_write_data,
    output logic [REQUESTERS-1:0]                 o_request_ack,
    output logic [REQUESTERS-1:0]                 o_response_valid,
    output logic [XLEN-1:0]                       o_read_data,
    output logic                                  o_error,
    output logic                                  o_csr_request,
    output logic                                  o_csr_write,
    output logic [ADDRESS_WIDTH-1:0]              o_csr_address,
    output logic [XLEN-1:0]                       o_csr_write_data,
    input  logic                                  i_csr_request_ack,
    input  logic                                  i_csr_response_valid,
    input  logic [XLEN-1:0]                       i_csr_read_data,
    input  logic                                  i_csr_error
);

    localparam int IDX_W = $clog2(REQUESTERS);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(REQUESTERS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        RESPONSE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          last_grant_q, last_grant_d;
    logic [IDX_W-1:0]          grant_q, grant_d;
    logic [REQUESTERS-1:0]     request_ack_q, request_ack_d;
    logic [REQUESTERS-1:0]     response_valid_q, response_valid_d;
    logic [XLEN-1:0]           read_data_q, read_data_d;
    logic                      error_q, error_d;
    logic                      csr_request_q, csr_request_d;
    logic                      csr_write_q, csr_write_d;
    logic [ADDRESS_WIDTH-1:0]  csr_address_q, csr_address_d;
    logic [XLEN-1:0]           csr_write_data_q, csr_write_data_d;

    logic                      w_found;
    logic [IDX_W-1:0]          w_sel;
    logic                      w_rsp_hit;
    logic                      w_tmo_hit;

    // Search upward from last_grant+1 with wrap; the last winner is checked last.
    always_comb begin
        w_found = 1'b0;
        w_sel   = last_grant_q;
        for (int i = 1; i <= REQUESTERS; i++) begin
            int cand;
            cand = int'(last_grant_q) + i;
            if (cand >= REQUESTERS) begin
                cand = cand - REQUESTERS;
            end
            if (!w_found && i_request[IDX_W'(cand)]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(cand);
            end
        end
    end

`ifdef RICE_CSR_ARBITER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] C_TIMEOUT = TMO_W'(TIMEOUT);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // A genuine response in the expiry cycle takes precedence.
    assign w_tmo_hit = (state_q != IDLE) && !w_rsp_hit && (tmo_cnt_q == C_TIMEOUT);
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        grant_d          = grant_q;
        request_ack_d    = '0;
        response_valid_d = '0;
        read_data_d      = read_data_q;
        error_d          = 1'b0;
        csr_request_d    = csr_request_q;
        csr_write_d      = csr_write_q;
        csr_address_d    = csr_address_q;
        csr_write_data_d = csr_write_data_q;
        w_rsp_hit        = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_found) begin
                    grant_d                = w_sel;
                    last_grant_d           = w_sel;
                    csr_write_d            = i_write[w_sel];
                    csr_address_d          = i_address[int'(w_sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    csr_write_data_d       = i_write_data[int'(w_sel)*XLEN +: XLEN];
                    request_ack_d[w_sel]   = 1'b1;
                    csr_request_d          = 1'b1;
                    state_d                = REQUEST;
                end
            end
            REQUEST: begin
                // A response without ack is not a response to our command.
                if (i_csr_request_ack) begin
                    csr_request_d = 1'b0;
                    if (i_csr_response_valid) begin
                        w_rsp_hit = 1'b1;
                    end else begin
                        state_d = RESPONSE;
                    end
                end
            end
            RESPONSE: begin
                if (i_csr_response_valid) begin
                    w_rsp_hit = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_rsp_hit) begin
            response_valid_d[grant_q] = 1'b1;
            read_data_d               = i_csr_read_data;
            error_d                   = i_csr_error;
            state_d                   = IDLE;
        end

        if (w_tmo_hit) begin
            response_valid_d[grant_q] = 1'b1;
            read_data_d               = '0;
            error_d                   = 1'b1;
            csr_request_d             = 1'b0;
            state_d                   = IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q          <= IDLE;
            last_grant_q     <= C_LAST_IDX;
            grant_q          <= '0;
            request_ack_q    <= '0;
            response_valid_q <= '0;
            read_data_q      <= '0;
            error_q          <= 1'b0;
            csr_request_q    <= 1'b0;
            csr_write_q      <= 1'b0;
            csr_address_q    <= '0;
            csr_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            grant_q          <= grant_d;
            request_ack_q    <= request_ack_d;
            response_valid_q <= response_valid_d;
            read_data_q      <= read_data_d;
            error_q          <= error_d;
            csr_request_q    <= csr_request_d;
            csr_write_q      <= csr_write_d;
            csr_address_q    <= csr_address_d;
            csr_write_data_q <= csr_write_data_d;
        end
    end

    assign o_request_ack    = request_ack_q;
    assign o_response_valid = response_valid_q;
    assign o_read_data      = read_data_q;
    assign o_error          = error_q;
    assign o_csr_request    = csr_request_q;
    assign o_csr_write      = csr_write_q;
    assign o_csr_address    = csr_address_q;
    assign o_csr_write_data = csr_write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_rice_csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rice_csr_arbiter
// Brief    : Directed self-checking bench for rice_csr_arbiter (2 requesters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rice_csr_arbiter;

    localparam int N  = 2;
    localparam int XL = 32;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, wr;
    logic [N*AW-1:0] addr;
    logic [N*XL-1:0] wdata;
    logic [N-1:0]    ack, rvalid;
    logic [XL-1:0]   rdata;
    logic            err;
    logic            csr_req, csr_wr;
    logic [AW-1:0]   csr_addr;
    logic [XL-1:0]   csr_wdata;
    logic            csr_ack, csr_rvalid, csr_err;
    logic [XL-1:0]   csr_rdata;

    int passed = 0;
    int total  = 0;

    rice_csr_arbiter #(
        .REQUESTERS(N), .XLEN(XL), .ADDRESS_WIDTH(AW), .TIMEOUT(8)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_request(req), .i_write(wr), .i_address(addr), .i_write_data(wdata),
        .o_request_ack(ack), .o_response_valid(rvalid),
        .o_read_data(rdata), .o_error(err),
        .o_csr_request(csr_req), .o_csr_write(csr_wr),
        .o_csr_address(csr_addr), .o_csr_write_data(csr_wdata),
        .i_csr_request_ack(csr_ack), .i_csr_response_valid(csr_rvalid),
        .i_csr_read_data(csr_rdata), .i_csr_error(csr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for any request ack; an expired bound is a failed check.
    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (ack == '0 && n < 20) begin
            tick();
            n++;
        end
        if (ack == '0) chk({tag, "_ack_seen"}, 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [N-1:0] exp_g;
        rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
        csr_ack = 1'b0; csr_rvalid = 1'b0; csr_rdata = '0; csr_err = 1'b0;
        tick();
        chk("rst_ack", ack, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_csr_req", csr_req, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        tick();

        // Single read by requester 0 of 0x300.
        req = 2'b01; addr = {12'h000, 12'h300};
        tick();
        chk("rd_ack", ack, 2'b01);
        chk("rd_csr_req", csr_req, 1);
        chk("rd_addr", csr_addr, 12'h300);
        chk("rd_wr", csr_wr, 0);
        req = '0;
        tick();
        chk("rd_ack_pulse", ack, 0);
        chk("rd_req_hold", csr_req, 1);
        chk("rd_addr_hold", csr_addr, 12'h300);
        csr_ack = 1'b1;
        tick();
        csr_ack = 1'b0;
        chk("rd_req_drop", csr_req, 0);
        tick();
        chk("rd_no_early_rsp", rvalid, 0);
        csr_rvalid = 1'b1; csr_rdata = 32'h0000_1888;
        tick();
        csr_rvalid = 1'b0; csr_rdata = '0;
        chk("rd_rvalid", rvalid, 2'b01);
        chk("rd_rdata", rdata, 32'h0000_1888);
        chk("rd_err", err, 0);
        tick();
        chk("rd_rvalid_pulse", rvalid, 0);
        chk("rd_rdata_hold", rdata, 32'h0000_1888);

        // Round-robin with both requesters active, after a fresh reset.
        do_reset();
        req = 2'b11; addr = {12'h111, 12'h222};
        wdata = {32'hBBBB_0001, 32'hAAAA_0000}; wr = 2'b00;
        exp_g = 2'b01;
        for (int k = 0; k < 6; k++) begin
            wait_ack("rr");
            chk("rr_grant", ack, exp_g);
            chk("rr_addr", csr_addr, (exp_g == 2'b01) ? 12'h222 : 12'h111);
            csr_ack = 1'b1;
            tick();
            csr_ack = 1'b0;
            chk("rr_ack_pulse", ack, 0);
            csr_rvalid = 1'b1; csr_rdata = 32'h100 + k;
            tick();
            csr_rvalid = 1'b0;
            chk("rr_rvalid", rvalid, exp_g);
            chk("rr_rdata", rdata, 32'h100 + k);
            exp_g = ~exp_g;
        end
        req = '0;
        tick();
        tick();

        // Requester 1 write with same-cycle ack and response.
        req = 2'b10; wr = 2'b10; addr = {12'h341, 12'h000};
        wdata = {32'h8000_0000, 32'h0};
        wait_ack("wr");
        chk("wr_grant", ack, 2'b10);
        chk("wr_flag", csr_wr, 1);
        chk("wr_addr", csr_addr, 12'h341);
        chk("wr_wdata", csr_wdata, 32'h8000_0000);
        req = '0; wr = '0;
        csr_ack = 1'b1; csr_rvalid = 1'b1; csr_rdata = 32'h0000_ABCD;
        tick();
        csr_ack = 1'b0; csr_rvalid = 1'b0;
        chk("wr_rvalid", rvalid, 2'b10);
        chk("wr_rdata", rdata, 32'h0000_ABCD);
        chk("wr_req_drop", csr_req, 0);

        // Response without ack in REQUEST must be ignored.
        tick();
        req = 2'b01; addr = {12'h000, 12'h123};
        wait_ack("err");
        req = '0;
        csr_rvalid = 1'b1; csr_rdata = 32'hDEAD_0000;
        tick();
        csr_rvalid = 1'b0;
        chk("noack_rsp_ignored", rvalid, 0);
        chk("noack_req_hold", csr_req, 1);
        csr_ack = 1'b1;
        tick();
        csr_ack = 1'b0;
        csr_rvalid = 1'b1; csr_err = 1'b1; csr_rdata = 32'h0000_0055;
        tick();
        csr_rvalid = 1'b0; csr_err = 1'b0;
        chk("err_rvalid", rvalid, 2'b01);
        chk("err_flag", err, 1);
        chk("err_rdata", rdata, 32'h0000_0055);
        tick();
        chk("err_clear", err, 0);
        chk("err_rvalid_pulse", rvalid, 0);

        // Reset while waiting in RESPONSE.
        req = 2'b01; addr = {12'h000, 12'h7C0};
        wait_ack("rm");
        req = '0;
        csr_ack = 1'b1;
        tick();
        csr_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("rm_async_rdata", rdata, 0);
        chk("rm_async_addr", csr_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        csr_rvalid = 1'b1; csr_rdata = 32'h1234_5678;
        tick();
        csr_rvalid = 1'b0;
        chk("rm_no_rsp", rvalid, 0);
        chk("rm_rdata", rdata, 0);
        req = 2'b10; addr = {12'h300, 12'h000};
        wait_ack("rm2");
        chk("rm_grant1", ack, 2'b10);
        chk("rm_addr1", csr_addr, 12'h300);
        req = '0;
        csr_ack = 1'b1; csr_rvalid = 1'b1; csr_rdata = 32'h0000_0077;
        tick();
        csr_ack = 1'b0; csr_rvalid = 1'b0;
        chk("rm_rvalid1", rvalid, 2'b10);

`ifdef RICE_CSR_ARBITER_TIMEOUT_EN
        tick();
        req = 2'b01;
        wait_ack("tmo");
        req = '0;
        for (int k = 0; k < 8; k++) tick();
        chk("tmo_not_yet", rvalid, 0);
        tick();
        chk("tmo_rvalid", rvalid, 2'b01);
        chk("tmo_err", err, 1);
        chk("tmo_rdata", rdata, 0);
        chk("tmo_csr_req", csr_req, 0);
        csr_rvalid = 1'b1; csr_rdata = 32'hFFFF_FFFF;
        tick();
        csr_rvalid = 1'b0;
        chk("tmo_late_ignored", rvalid, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
